mbist_fail_log: RTL
===================

# mbist_fail_log

Failure capture stage directly downstream of the memory BIST top level. On every qualified failing compare it records the failing address (TAS), the formatted operation (TCS) and the bit syndrome (expected TDS XOR memory read data) into a small FIFO. It keeps a saturating failure count and a sticky overflow flag. Entries drain through a valid/ready read port to the diagnosis or scan-out logic.

## Interface
- `aw`, `ADDR_WIDTH`: TAS / logged address width
- `cw`, `MARCH_SEQ_FRMT_SIZE`: TCS / logged operation width
- `dw`, `DATA_WIDTH`: TDS, memory data and syndrome width
- `depth`, `FAIL_LOG_DEPTH` (8): FIFO entries; power of two, at least 2
- `cntw`, `FAIL_CNT_WIDTH` (16): failure counter width

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `test_active_in`  in  1  high while a march test runs
- `clear_in`  in  1  synchronous flush of FIFO, count and flags
- `cmp_valid_in`  in  1  current cycle carries a valid read compare
- `passfail_in`  in  1  compare result; 1 = mismatch (fail)
- `tas_in`  in  aw  address of the compared read
- `tcs_in`  in  cw  formatted operation of the compared read
- `tds_in`  in  dw  expected data
- `mem_in`  in  dw  data read from memory
- `rd_valid_out`  out  1  head entry available
- `rd_ready_in`  in  1  consumer accepts the head entry
- `rd_addr_out`  out  aw  head entry address
- `rd_op_out`  out  cw  head entry operation
- `rd_syn_out`  out  dw  head entry syndrome
- `fail_count_out`  out  cntw  total failures seen since the last clear; saturating
- `overflow_out`  out  1  sticky; at least one failure was dropped
- `state_out`  out  2  FSM state: IDLE=0, ARMED=1, DRAIN=2

## Operation
- **FSM states**
  - IDLE: nothing is captured.
  - IDLE→ARMED when `test_active_in` is high.
  - ARMED→DRAIN when `test_active_in` falls.
  - DRAIN→IDLE when the FIFO is empty, or on `clear_in`.
  - DRAIN→ARMED when `test_active_in` rises again; existing entries are kept.
- **Capture condition:** state ARMED and `cmp_valid_in` and `passfail_in`.
- **Entry contents:** {`tcs_in`, `tas_in`, `tds_in ^ mem_in`}.
- **Failure count:** increments on every capture condition, whether or not the entry is stored. It holds at all-ones once saturated.
- **Full FIFO:** a capture with no simultaneous pop is dropped and sets `overflow_out`.
- **Full FIFO with pop:** a capture that coincides with a pop is stored.
- **Pop:** occurs when `rd_valid_out` and `rd_ready_in` are both high. A pop is allowed in every state.
- **Empty FIFO:** `rd_valid_out` is 0. The read data outputs hold their last value and carry no meaning.
- **`clear_in` priority:** `clear_in` overrides capture and pop in the same cycle.
  - Pointers, count and overflow go to 0.
  - The state goes to IDLE, or to ARMED if `test_active_in` is high.
- **Pointer arithmetic:** pointers are log2(`depth`)+1 bits; the MSB marks wrap. The FIFO is full when the low bits are equal and the MSBs differ.

## Timing
- **Reset values:** all outputs are 0 and the state is IDLE.
- **Reset mid-test:** the log is lost with no recovery.
- **Capture latency:** a capture in cycle N makes the entry visible in cycle N+1.
  - With an empty FIFO, `rd_valid_out` rises in N+1.
  - `fail_count_out` and `overflow_out` update in N+1.
- **Pop:** the next head entry appears the cycle after the pop.
- **Read port:** registered outputs; no combinational path from any input to any output.
- **Failing compare in the same cycle as the `test_active_in` fall:** captured only if the FSM was already ARMED (the FSM is still ARMED in that cycle).
- **Consumer back-pressure:** the consumer may hold `rd_ready_in` low indefinitely. The BIST is never stalled; dropped failures show up only as count and overflow.

## Configuration
- **`FAIL_LOG_DEDUP_EN` defined:**
  - A capture whose address and operation equal the most recently stored entry is not stored.
  - It still increments `fail_count_out`.
  - The last-stored register clears on `clear_in` and on reset.
- **`FAIL_LOG_DEDUP_EN` undefined:** every capture is stored, subject to space.

## Structure
- **Constants in the shared defines include:**
  - `FAIL_LOG_DEPTH`
  - `FAIL_CNT_WIDTH`
  - FSM state encodings `FL_IDLE`, `FL_ARMED`, `FL_DRAIN`
  - entry width macro `FAIL_ENTRY_WIDTH` = cw+aw+dw
- **Sub-module:** `fail_fifo`, a parameterised synchronous FIFO with push/pop, full/empty and a registered head.
- **Top of the block:** FSM, counter, overflow and dedup logic.

## Test plan
- **Single fail:** ARMED, 1 cycle with `cmp_valid_in`=1, `passfail_in`=1, `tas_in`=0x12, `tds_in`=0xAA, `mem_in`=0xA8 → next cycle `rd_valid_out`=1, `rd_addr_out`=0x12, `rd_syn_out`=0x02, `fail_count_out`=1.
- **Overflow:** `depth`=8, 10 consecutive failures with `rd_ready_in`=0 → 8 entries stored in order, `fail_count_out`=10, `overflow_out`=1.
- **Full with pop:** FIFO full, failure and pop in the same cycle → new entry stored, `overflow_out` stays 0.
- **Clear vs capture:** `clear_in` together with a failure → next cycle count 0, `rd_valid_out`=0, `overflow_out`=0.
- **FSM path:** `test_active_in` 1→0 with 3 entries queued → DRAIN; drain all 3 → IDLE; failures in IDLE → ignored, count unchanged.
- **Dedup:** `FAIL_LOG_DEDUP_EN` defined, two identical failures at 0x05 → one entry, `fail_count_out`=2. Macro undefined → two entries.

Source files
------------

// File: rtl/mbist_fail_log_pkg.sv
// rtl/mbist_fail_log_pkg.sv - shared constants and types for the MBIST failure log
//
// Purpose : default FIFO depth and counter width, FSM state encodings and the
//           log entry width helper shared by mbist_fail_log and fail_fifo.
// Ports   : none (package).
package mbist_fail_log_pkg;

  localparam int FAIL_LOG_DEPTH = 8;
  localparam int FAIL_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    FL_IDLE  = 2'd0,
    FL_ARMED = 2'd1,
    FL_DRAIN = 2'd2
  } fl_state_e;

  // Entry layout is {operation, address, syndrome}.
  function automatic int fail_entry_width(input int cw, input int aw, input int dw);
    return cw + aw + dw;
  endfunction

endpackage

// File: rtl/fail_fifo.sv
// rtl/fail_fifo.sv - synchronous FIFO with registered head entry
//
// Purpose : stores failure log entries; the head entry is held in a register so
//           the read port has no combinational path from any input.
// Ports   : clk, rst (async active-low), clear (sync flush), push/din write side,
//           pop read side, full/empty flags, head (registered head entry).
module fail_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int LW = $clog2(DEPTH);
  localparam int PW = LW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  head_q, head_n;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[LW-1:0] == rd_ptr[LW-1:0]) && (wr_ptr[LW] != rd_ptr[LW]);
  assign head  = head_q;

  // head_n is the entry that will sit at rd_ptr_n after this edge. If that slot
  // is the one being written right now, forward din instead of the stale RAM.
  // When the FIFO goes empty the head simply holds its last value.
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    head_n   = head_q;
    if (clear) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
    end else begin
      if (push) wr_ptr_n = wr_ptr + PW'(1);
      if (pop)  rd_ptr_n = rd_ptr + PW'(1);
      if (wr_ptr_n != rd_ptr_n) begin
        if (push && (wr_ptr[LW-1:0] == rd_ptr_n[LW-1:0])) head_n = din;
        else                                              head_n = mem[rd_ptr_n[LW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[LW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head_q <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      head_q <= head_n;
    end
  end

endmodule

// File: rtl/mbist_fail_log.sv
// rtl/mbist_fail_log.sv - MBIST failure capture log with saturating count and overflow
//
// Purpose : captures {operation, address, syndrome} of every failing compare
//           while armed into fail_fifo, counts failures (saturating) and flags
//           dropped failures. Optional macro FAIL_LOG_DEDUP_EN suppresses storing
//           a capture whose address/operation match the last stored entry.
// Ports   : clk, rst (async active-low), test_active_in, clear_in,
//           compare side cmp_valid_in/passfail_in/tas_in/tcs_in/tds_in/mem_in,
//           read side rd_valid_out/rd_ready_in/rd_addr_out/rd_op_out/rd_syn_out,
//           status fail_count_out, overflow_out, state_out.
module mbist_fail_log
  import mbist_fail_log_pkg::*;
#(
  parameter int aw    = 8,
  parameter int cw    = 4,
  parameter int dw    = 8,
  parameter int depth = FAIL_LOG_DEPTH,
  parameter int cntw  = FAIL_CNT_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            test_active_in,
  input  logic            clear_in,
  input  logic            cmp_valid_in,
  input  logic            passfail_in,
  input  logic [aw-1:0]   tas_in,
  input  logic [cw-1:0]   tcs_in,
  input  logic [dw-1:0]   tds_in,
  input  logic [dw-1:0]   mem_in,
  output logic            rd_valid_out,
  input  logic            rd_ready_in,
  output logic [aw-1:0]   rd_addr_out,
  output logic [cw-1:0]   rd_op_out,
  output logic [dw-1:0]   rd_syn_out,
  output logic [cntw-1:0] fail_count_out,
  output logic            overflow_out,
  output logic [1:0]      state_out
);

  localparam int EW = fail_entry_width(cw, aw, dw);

  fl_state_e       state_q, state_n;
  logic            capture, push, pop, ovf_set, dup;
  logic            fifo_full, fifo_empty;
  logic [EW-1:0]   head;
  logic [cntw-1:0] cnt_q;
  logic            ovf_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FL_IDLE;
    else      state_q <= state_n;
  end

  // Next-state logic; clear wins over every other transition.
  always_comb begin
    state_n = state_q;
    if (clear_in) begin
      state_n = test_active_in ? FL_ARMED : FL_IDLE;
    end else begin
      case (state_q)
        FL_IDLE:  if (test_active_in) state_n = FL_ARMED;
        FL_ARMED: if (!test_active_in) state_n = FL_DRAIN;
        FL_DRAIN: begin
          if (test_active_in)  state_n = FL_ARMED;
          else if (fifo_empty) state_n = FL_IDLE;
        end
        default:  state_n = FL_IDLE;
      endcase
    end
  end

  // Output/control logic. A capture into a full FIFO still fits if the head
  // is popped in the same cycle.
  always_comb begin
    capture = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    if (!clear_in) begin
      capture = (state_q == FL_ARMED) && cmp_valid_in && passfail_in;
      pop     = !fifo_empty && rd_ready_in;
      push    = capture && !dup && (!fifo_full || pop);
      ovf_set = capture && !dup && fifo_full && !pop;
    end
  end

`ifdef FAIL_LOG_DEDUP_EN
  logic          last_vld;
  logic [aw-1:0] last_addr;
  logic [cw-1:0] last_op;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_vld  <= 1'b0;
      last_addr <= '0;
      last_op   <= '0;
    end else if (clear_in) begin
      last_vld  <= 1'b0;
      last_addr <= '0;
      last_op   <= '0;
    end else if (push) begin
      last_vld  <= 1'b1;
      last_addr <= tas_in;
      last_op   <= tcs_in;
    end
  end

  assign dup = last_vld && (tas_in == last_addr) && (tcs_in == last_op);
`else
  assign dup = 1'b0;
`endif

  // Count every qualified failure, stored or not; saturate at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear_in) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (capture && !(&cnt_q)) cnt_q <= cnt_q + cntw'(1);
      if (ovf_set)              ovf_q <= 1'b1;
    end
  end

  fail_fifo #(
    .W     (EW),
    .DEPTH (depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_in),
    .push  (push),
    .din   ({tcs_in, tas_in, tds_in ^ mem_in}),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  assign rd_valid_out   = !fifo_empty;
  assign rd_op_out      = head[EW-1 -: cw];
  assign rd_addr_out    = head[dw +: aw];
  assign rd_syn_out     = head[dw-1:0];
  assign fail_count_out = cnt_q;
  assign overflow_out   = ovf_q;
  assign state_out      = state_q;

endmodule
